// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for a 5-stage pipeline.
// Tracks destination info for EX/MEM/WB and counts stall cycles (saturating).
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic                  freeze,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  // EX keeps the load flag and sources; past EX only the write-back identity matters.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } ex_rec_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } wr_rec_t;

  ex_rec_t          r_ex;
  wr_rec_t          r_mem;
  wr_rec_t          r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  logic    w_hazard;
  logic    w_stall;
  logic    w_bubble;
  logic    w_mem_fwd_ok;
  logic    w_wb_fwd_ok;
  ex_rec_t w_ex_next;

  // Load in EX whose result an ID source needs; x0 is hardwired and never waits.
  assign w_hazard = id_valid && r_ex.valid && r_ex.mem_read &&
                    (r_ex.rd != '0) &&
                    ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));

  // A squashed ID instruction cannot depend on anything.
  assign w_stall  = w_hazard && !flush;
  assign w_bubble = w_stall || flush || !id_valid;

  assign w_mem_fwd_ok = r_ex.valid && r_mem.valid && r_mem.reg_write && (r_mem.rd != '0);
  assign w_wb_fwd_ok  = r_ex.valid && r_wb.valid  && r_wb.reg_write  && (r_wb.rd  != '0);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    // MEM is checked first: the newest producer of a register wins.
    if (w_mem_fwd_ok && (r_mem.rd == r_ex.rs1))     fwd_a_sel = SEL_MEM;
    else if (w_wb_fwd_ok && (r_wb.rd == r_ex.rs1))  fwd_a_sel = SEL_WB;
    if (w_mem_fwd_ok && (r_mem.rd == r_ex.rs2))     fwd_b_sel = SEL_MEM;
    else if (w_wb_fwd_ok && (r_wb.rd == r_ex.rs2))  fwd_b_sel = SEL_WB;
  end

  always_comb begin
    w_ex_next           = '0;
    w_ex_next.rs1       = id_rs1;
    w_ex_next.rs2       = id_rs2;
    if (!w_bubble) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.rd        = id_rd;
      w_ex_next.reg_write = id_reg_write;
      w_ex_next.mem_read  = id_mem_read;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!freeze) begin
      r_wb  <= r_mem;
      r_mem <= '{valid: r_ex.valid, rd: r_ex.rd, reg_write: r_ex.reg_write};
      r_ex  <= w_ex_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !freeze && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: expected sels/stall/count queued per step,
// popped after outputs settle. A CNT_W=4 copy shares the stimulus to show saturation.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, flush, freeze;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel4, fwd_b_sel4;
  logic       stall, stall4;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        st;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .freeze(freeze), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .freeze(freeze), .fwd_a_sel(fwd_a_sel4), .fwd_b_sel(fwd_b_sel4),
    .stall(stall4), .stall_cnt(stall_cnt4)
  );

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (fwd_a_sel === e.a) else begin
      bad++; $error("FAIL %s fwd_a_sel got=%b want=%b", e.tag, fwd_a_sel, e.a);
    end
    total++;
    assert (fwd_b_sel === e.b) else begin
      bad++; $error("FAIL %s fwd_b_sel got=%b want=%b", e.tag, fwd_b_sel, e.b);
    end
    total++;
    assert (stall === e.st) else begin
      bad++; $error("FAIL %s stall got=%b want=%b", e.tag, stall, e.st);
    end
    total++;
    assert (stall_cnt === e.cnt) else begin
      bad++; $error("FAIL %s stall_cnt got=%0d want=%0d", e.tag, stall_cnt, e.cnt);
    end
    total++;
    assert (stall_cnt4 === e.cnt4) else begin
      bad++; $error("FAIL %s stall_cnt4 got=%0d want=%0d", e.tag, stall_cnt4, e.cnt4);
    end
  endtask

  // One cycle: drive ID/control inputs after the falling edge, queue expectations, check.
  task automatic step(input string tag, input logic v, input logic [4:0] rs1, rs2, rd,
                      input logic rw, mr, fl, fz,
                      input logic [1:0] ea, eb, input logic es, input int ecnt);
    exp_t e;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; flush = fl; freeze = fz;
    e.tag = tag; e.a = ea; e.b = eb; e.st = es;
    e.cnt  = 32'(ecnt);
    e.cnt4 = (ecnt > 15) ? 4'd15 : 4'(ecnt);
    sb.push_back(e);
    #1;
    check_out();
  endtask

  task automatic nop(input string tag, input logic [1:0] ea, eb, input int ecnt);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b0, ecnt);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0; freeze = 1'b0;

    // Reset for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1;
      id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
      id_rd = 5'($urandom); id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
      flush = 1'($urandom); freeze = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    nop("reset", 2'b00, 2'b00, 0);

    // add x5,x1,x2 ; sub x6,x5,x7 -> consumer in EX forwards A from EX/MEM.
    step("alu_prod",  1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("alu_cons",  1, 5'd5, 5'd7, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("b2b_fwd",    2'b10, 2'b00, 0);
    for (int i = 0; i < 3; i++) nop("drain1", 2'b00, 2'b00, 0);

    // One independent op between producer and consumer -> A from MEM/WB.
    step("gap_prod",  1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("gap_indep", 1, 5'd1, 5'd2, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("gap_cons",  1, 5'd5, 5'd7, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("gap_fwd",    2'b01, 2'b00, 0);
    for (int i = 0; i < 3; i++) nop("drain2", 2'b00, 2'b00, 0);

    // MEM and WB both write x5; consumer reads x5 twice -> newest (EX/MEM) wins.
    step("dbl_old",   1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("dbl_new",   1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("dbl_cons",  1, 5'd5, 5'd5, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("dbl_fwd",    2'b10, 2'b10, 0);
    for (int i = 0; i < 3; i++) nop("drain3", 2'b00, 2'b00, 0);

    // lw x3 ; add x4,x3,x3 -> one stall cycle, bubble, then both from MEM/WB.
    step("lu_load",   1, 5'd2, 5'd0, 5'd3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    step("lu_stall",  1, 5'd3, 5'd3, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    step("lu_bubble", 1, 5'd3, 5'd3, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    nop("lu_fwd",     2'b01, 2'b01, 1);
    for (int i = 0; i < 3; i++) nop("drain4", 2'b00, 2'b00, 1);

    // lw x0 ; add x1,x0,x0 -> x0 never stalls or forwards.
    step("x0_load",   1, 5'd2, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    step("x0_cons",   1, 5'd0, 5'd0, 5'd1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    nop("x0_fwd",     2'b00, 2'b00, 1);
    for (int i = 0; i < 3; i++) nop("drain5", 2'b00, 2'b00, 1);

    // Load-use with flush in the hazard cycle -> no stall, count unchanged.
    step("fl_load",   1, 5'd2, 5'd0, 5'd3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    step("fl_hazard", 1, 5'd3, 5'd3, 5'd4, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1);
    nop("fl_after",   2'b00, 2'b00, 1);
    for (int i = 0; i < 3; i++) nop("drain6", 2'b00, 2'b00, 1);

    // Load-use held by freeze for 3 cycles -> stall held, one increment after release.
    step("fz_load",   1, 5'd2, 5'd0, 5'd3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    for (int i = 0; i < 3; i++)
      step("fz_hold", 1, 5'd3, 5'd3, 5'd4, 1, 0, 0, 1, 2'b00, 2'b00, 1, 1);
    step("fz_stall",  1, 5'd3, 5'd3, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    step("fz_bubble", 1, 5'd3, 5'd3, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2);
    nop("fz_fwd",     2'b01, 2'b01, 2);

    // Repeated load-use: 32-bit count keeps climbing, 4-bit copy pins at 15.
    for (int i = 0; i < 18; i++) begin
      step("sat_load",   1, 5'd2, 5'd0, 5'd3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2 + i);
      step("sat_stall",  1, 5'd3, 5'd3, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 1, 2 + i);
      step("sat_bubble", 1, 5'd3, 5'd3, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 3 + i);
      nop("sat_fwd",     2'b01, 2'b01, 3 + i);
    end

    // Reset while a hazard is pending drops stall right away.
    step("rs_load",   1, 5'd2, 5'd0, 5'd3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 20);
    step("rs_stall",  1, 5'd3, 5'd3, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 1, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step("rs_clear",  1, 5'd3, 5'd3, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard ceiling so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout waiting for stimulus to complete");
    $fatal(1, "timeout");
  end

endmodule
